// File: rtl/elevator_pkg.sv
// Shared widths, floor limits, direction encoding and FSM states for elevator_ctrl.
package elevator_pkg;
  localparam int FLOOR_W    = 3;
  localparam int CNT_W      = 6;
  localparam int NUM_FLOORS = 7;
  localparam int NUM_CARS   = 2;

  localparam logic [FLOOR_W-1:0] FLOOR_MIN = 3'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_MAX = 3'd7;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Floor 0 does not exist; a car loaded there starts on floor 1.
  function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] f);
    return (f == '0) ? FLOOR_MIN : f;
  endfunction
endpackage

// File: rtl/elevator_car.sv
// One elevator car: holds floor and direction, decides pick-up vs. move
// from the count waiting at its floor, and reports how many it takes.
module elevator_car
  import elevator_pkg::*;
#(
  parameter int CAP = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FLOOR_W-1:0] init_floor,
  input  logic               init_dir,
  input  logic               adv,
  input  logic [CNT_W-1:0]   avail,
  output logic [FLOOR_W-1:0] floor,
  output logic [CNT_W-1:0]   take
);
  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAP);

  logic               dir, nxt_dir;
  logic [FLOOR_W-1:0] nxt_floor;

  // Take everything waiting, limited to the car capacity; zero means move.
  always_comb begin
    take = avail;
    if (avail > CAP_V) take = CAP_V;
  end

  // Move one floor when nothing to take; turn around at the ends first.
  always_comb begin
    nxt_dir   = dir;
    nxt_floor = floor;
    if (take == '0) begin
      if (dir == DIR_UP && floor == FLOOR_MAX)        nxt_dir = DIR_DOWN;
      else if (dir == DIR_DOWN && floor == FLOOR_MIN) nxt_dir = DIR_UP;
      nxt_floor = (nxt_dir == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    end
  end

  // Floor/direction register: load wins over a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      floor <= FLOOR_MIN;
      dir   <= DIR_UP;
    end else if (load) begin
      floor <= clamp_floor(init_floor);
      dir   <= init_dir;
    end else if (adv) begin
      floor <= nxt_floor;
      dir   <= nxt_dir;
    end
  end
endmodule

// File: rtl/elevator_ctrl.sv
// Two-car elevator simulator over floors 1..7.
// Optional statistics counters (picked_total, move_count) are built only
// when ELEVATOR_STATS_EN is defined; otherwise those ports read 0.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int CAP = 8
) (
  input  logic               clk,
  input  logic               reset_start,
  input  logic               load,
  input  logic               step,
  input  logic [CNT_W-1:0]   remaining_1,
  input  logic [CNT_W-1:0]   remaining_2,
  input  logic [CNT_W-1:0]   remaining_3,
  input  logic [CNT_W-1:0]   remaining_4,
  input  logic [CNT_W-1:0]   remaining_5,
  input  logic [CNT_W-1:0]   remaining_6,
  input  logic [CNT_W-1:0]   remaining_7,
  input  logic [FLOOR_W-1:0] curr_elevator_1,
  input  logic [FLOOR_W-1:0] curr_elevator_2,
  input  logic [1:0]         dir_elevator,
  output logic [FLOOR_W-1:0] floor_1,
  output logic [FLOOR_W-1:0] floor_2,
  output logic [CNT_W-1:0]   left_1,
  output logic [CNT_W-1:0]   left_2,
  output logic [CNT_W-1:0]   left_3,
  output logic [CNT_W-1:0]   left_4,
  output logic [CNT_W-1:0]   left_5,
  output logic [CNT_W-1:0]   left_6,
  output logic [CNT_W-1:0]   left_7,
  output logic               busy,
  output logic               done,
  output logic [8:0]         picked_total,
  output logic [7:0]         move_count
);
  state_t state_q, state_d;

  logic [NUM_FLOORS-1:0][CNT_W-1:0]  cnt, ld_cnt, cnt_nxt;
  logic [NUM_CARS-1:0][FLOOR_W-1:0]  init_floor, car_floor;
  logic [NUM_CARS-1:0]               init_dir;
  logic                              adv;

`ifdef ELEVATOR_STATS_EN
  logic [NUM_CARS-1:0][CNT_W-1:0]    take_v;
`endif

  assign ld_cnt     = {remaining_7, remaining_6, remaining_5, remaining_4,
                       remaining_3, remaining_2, remaining_1};
  assign init_floor = {curr_elevator_2, curr_elevator_1};
  assign init_dir   = {dir_elevator[0], dir_elevator[1]};

  // A load in RUN restarts the run, so it masks the concurrent step.
  assign adv = (state_q == RUN) && step && !load;

  // Cars are chained: each sees the counts left after the cars before it,
  // so on a shared floor car 1 takes first and car 2 takes the remainder.
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    logic [NUM_FLOORS-1:0][CNT_W-1:0] cnt_in, cnt_out;
    logic [CNT_W-1:0]                 avail, take;
    logic [FLOOR_W-1:0]               idx;

    if (g == 0) begin : g_head
      assign cnt_in = cnt;
    end else begin : g_chain
      assign cnt_in = g_car[g-1].cnt_out;
    end

    assign idx   = car_floor[g] - FLOOR_MIN;
    assign avail = cnt_in[idx];

    // Remove this car's pick-up from the running counts.
    always_comb begin
      cnt_out      = cnt_in;
      cnt_out[idx] = cnt_in[idx] - take;
    end

`ifdef ELEVATOR_STATS_EN
    assign take_v[g] = take;
`endif

    elevator_car #(.CAP(CAP)) u_car (
      .clk        (clk),
      .rst        (reset_start),
      .load       (load),
      .init_floor (init_floor[g]),
      .init_dir   (init_dir[g]),
      .adv        (adv),
      .avail      (avail),
      .floor      (car_floor[g]),
      .take       (take)
    );
  end

  assign cnt_nxt = g_car[NUM_CARS-1].cnt_out;

  // State register.
  always_ff @(posedge clk or posedge reset_start) begin
    if (reset_start) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state: load from any state; finish when a step empties every floor.
  always_comb begin
    state_d = state_q;
    if (load)                        state_d = (ld_cnt == '0) ? DONE : RUN;
    else if (adv && cnt_nxt == '0)   state_d = DONE;
  end

  // Waiting-count register.
  always_ff @(posedge clk or posedge reset_start) begin
    if (reset_start) cnt <= '0;
    else if (load)   cnt <= ld_cnt;
    else if (adv)    cnt <= cnt_nxt;
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign floor_1 = car_floor[0];
  assign floor_2 = car_floor[1];
  assign left_1  = cnt[0];
  assign left_2  = cnt[1];
  assign left_3  = cnt[2];
  assign left_4  = cnt[3];
  assign left_5  = cnt[4];
  assign left_6  = cnt[5];
  assign left_7  = cnt[6];

`ifdef ELEVATOR_STATS_EN
  logic [8:0] picked_q, pick_sum;
  logic [7:0] moves_q;
  logic [1:0] move_sum;
  logic [8:0] moves_wide;

  // Per-step totals: passengers taken, and cars that moved (took nothing).
  always_comb begin
    pick_sum = '0;
    move_sum = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      pick_sum = pick_sum + 9'(take_v[i]);
      if (take_v[i] == '0) move_sum = move_sum + 2'd1;
    end
    moves_wide = 9'(moves_q) + 9'(move_sum);
  end

  // Statistics: cleared on load, move count saturates at 255.
  always_ff @(posedge clk or posedge reset_start) begin
    if (reset_start) begin
      picked_q <= '0;
      moves_q  <= '0;
    end else if (load) begin
      picked_q <= '0;
      moves_q  <= '0;
    end else if (adv) begin
      picked_q <= picked_q + pick_sum;
      moves_q  <= (moves_wide > 9'd255) ? 8'd255 : moves_wide[7:0];
    end
  end

  assign picked_total = picked_q;
  assign move_count   = moves_q;
`else
  assign picked_total = '0;
  assign move_count   = '0;
`endif
endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter CAP, default 8, the maximum passengers one car picks up per step (1..63).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_start, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port load, input, 1, a one-cycle pulse that latches the initial state.
REQ-005 SHALL have port step, input, 1, the advance enable; one simulation step per cycle when high.
REQ-006 SHALL have ports remaining_1..remaining_7, input, 6 each, the initial waiting count per floor 1..7.
REQ-007 SHALL have ports curr_elevator_1, curr_elevator_2, input, 3 each, the initial car floors.
REQ-008 SHALL have port dir_elevator, input, 2, the initial directions: bit1 = car 1, bit0 = car 2; 1 = up, 0 = down.
REQ-009 SHALL have ports floor_1, floor_2, output, 3 each, the current car floors.
REQ-010 SHALL have ports left_1..left_7, output, 6 each, the passengers still waiting per floor.
REQ-011 SHALL have ports busy and done, output, 1 each, the run-status flags.
REQ-012 SHALL have ports picked_total (9 bits) and move_count (8 bits), output, the statistics.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL take the following transitions:
- IDLE: load -> RUN.
- RUN: all left_* zero after an update -> DONE.
- DONE: load -> RUN.
- RUN: load -> reload and stay in RUN (restart); load has priority over step.
REQ-015 SHALL, on load, copy the inputs into the floor/count/direction registers on the next edge, with a floor value of 0 clamped to 1.
REQ-016 SHALL, on load when all loaded counts are zero, enter DONE directly.
REQ-017 SHALL, per step cycle in RUN, have each car either pick up or move, never both:
- Pick up when the waiting count at its floor is >0: take min(CAP, count) and subtract it.
- Otherwise move one floor in its direction.
REQ-018 SHALL reverse direction at the boundaries: a car at floor 7 heading up, or at floor 1 heading down, reverses and moves in the same step.
REQ-019 SHALL, when both cars are on the same floor, let car 1 take first and car 2 take from the remainder in the same cycle.
REQ-020 SHALL register all updates with a 1-cycle latency from step to the visible outputs.
REQ-021 SHALL hold all state while step=0 and ignore step in IDLE and DONE.
REQ-022 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE.
REQ-023 SHALL increment picked_total by the passengers taken per step; it cannot exceed 441.
REQ-024 SHALL increment move_count by the number of cars that moved, saturating at 255.
REQ-025 SHALL clear both statistics on load.

Reset
REQ-026 SHALL, on reset_start high, asynchronously force state IDLE, floor_1=floor_2=1, directions up, all left_*=0, busy=0, done=0 and statistics 0.
REQ-027 SHALL abandon the run on reset_start mid-RUN; a subsequent load is required.

Configuration
REQ-028 SHALL compile the statistics counters only when macro ELEVATOR_STATS_EN is defined.
REQ-029 SHALL tie picked_total and move_count to constant 0 when ELEVATOR_STATS_EN is undefined, with the ports still present and all other behaviour identical.

Structure
REQ-030 SHALL place the following in shared package elevator_pkg:
- floor width 3 and count width 6;
- the floor limits 1 and 7;
- the direction encoding UP=1, DOWN=0;
- the FSM state enum.
REQ-031 SHALL implement each car as sub-module elevator_car, instanced twice; it holds floor and direction and computes pick-or-move and the take amount.

Verification
REQ-032 SHALL cover the following directed scenarios:
- Load counts {3,0,0,0,0,0,0}, car 1 at 1, car 2 at 7, dir 2'b10, step held high -> car 1 takes 3 in the first step; left_1=0; done=1 one cycle later; picked_total=3.
- Car 1 at floor 7 with dir bit1=1, no waiting on floor 7, step pulse -> floor_1=6 and car 1 direction down.
- Both cars on floor 4, left_4=10, CAP=8, one step -> car 1 takes 8, car 2 takes 2, left_4=0.
- Load in RUN -> registers reloaded and statistics cleared; the concurrent step is ignored.
- reset_start asserted mid-RUN, asynchronously between edges -> outputs at reset values immediately; busy=0.
- ELEVATOR_STATS_EN undefined -> picked_total and move_count stay 0 across a full run; all other outputs match the stats build.
